serial_pattern_tx: RTL and testbench

Parametrised serial bit-stream generator driving an external pin pair (serial clock plus data), for example the J3 header. It replaces free-running, hard-wired pattern rotation with a loadable shift register and a runtime-programmable bit-clock divider. Two modes are supported: one-shot frames with a valid/ready load handshake, and continuous rotation of a loaded pattern with a per-frame strobe. It sits in the sysclk (PLL output) domain, between control logic and the output pins.

---
 rtl/serial_pattern_tx_pkg.sv | 19 +
 rtl/serial_pattern_tx_if.sv | 35 +++
 rtl/serial_pattern_tx_clk_div_toggle.sv | 46 ++++
 rtl/serial_pattern_tx.sv | 135 +++++++++++++
 tb/tb_serial_pattern_tx.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   - State encoding for the transmit FSM (IDLE / SHIFT / ROTATE).
//   - Mode constants for the per-frame mode input.
package serial_pattern_tx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_ROTATE = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        ROTATE = ST_ROTATE
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_ROTATE  = 1'b1;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Control-side bundle of the serial pattern transmitter.
//   div        : half-bit period minus 1 (clk cycles), sampled at acceptance
//   mode       : 0 = one-shot frame, 1 = continuous rotation
//   load_valid : load_data is valid
//   load_data  : frame / pattern to send
//   load_ready : transmitter can accept a frame this cycle
//   stop       : in rotation, finish the current frame then go idle
//   busy       : transmitter is not idle
//   done       : one-cycle pulse at the end of every frame
// master = control logic, slave = transmitter.
interface serial_pattern_tx_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) ();

    logic [DIV_W-1:0]  div;
    logic              mode;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              stop;
    logic              busy;
    logic              done;

    modport master (
        output div, mode, load_valid, load_data, stop,
        input  load_ready, busy, done
    );

    modport slave (
        input  div, mode, load_valid, load_data, stop,
        output load_ready, busy, done
    );

endinterface

// File: rtl/serial_pattern_tx_clk_div_toggle.sv
// Programmable half-period divider producing a toggling serial clock.
//   clk, rst : system clock, asynchronous active-high reset
//   en       : count while high (transmitter active)
//   clr      : synchronous clear of counter and sck (has priority over en)
//   div      : half period minus 1, in clk cycles
//   sck      : divided clock, low after reset/clear
//   wrap     : counter reaches div this cycle, sck toggles on the next edge
//   fall     : wrap while sck is high, i.e. the next edge is a falling toggle
module clk_div_toggle #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             sck,
    output logic             wrap,
    output logic             fall
);

    logic [DIV_W-1:0] cnt_q;

    assign wrap = en && (cnt_q == div);
    assign fall = wrap && sck;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            sck   <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            sck   <= 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_q <= '0;
                sck   <= ~sck;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Loadable serial bit-stream generator (serial clock + data pin pair).
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : control bundle (slave side): div, mode, load handshake,
//              stop, busy, done
//   sck      : serial clock, idle low; receiver samples on the rising edge
//   sdo      : serial data, only changes while sck is low
// One-shot mode sends a single frame; rotate mode repeats the loaded
// pattern until stop is seen, always finishing the frame in progress.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_pattern_tx_if.slave    bus,
    output logic                  sck,
    output logic                  sdo
);

    localparam int              BC_W     = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_next;
    logic [DIV_W-1:0]  div_q;
    logic [BC_W-1:0]   bit_cnt_q;
    logic              sdo_q, done_q, stop_q;
    logic              load_ready, accept, frame_end, stop_now;
    logic              wrap, fall, rot_in;

    function automatic logic first_bit(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    clk_div_toggle #(.DIV_W(DIV_W)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .clr  (accept),
        .div  (div_q),
        .sck  (sck),
        .wrap (wrap),
        .fall (fall)
    );

    // Rotation feeds the outgoing bit back in, so after DATA_W shifts the
    // pattern is back where it started; one-shot frames shift in zeros.
    assign rot_in = (state_q == ROTATE);

    always_comb begin
        if (LSB_FIRST) begin
            shreg_next = {rot_in & shreg_q[0], shreg_q[DATA_W-1:1]};
        end else begin
            shreg_next = {shreg_q[DATA_W-2:0], rot_in & shreg_q[DATA_W-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        case (state_q)
            IDLE:    load_ready = 1'b1;
            // Final cycle of a one-shot frame: the next edge is the last
            // falling toggle, so a new frame can start without a gap.
            SHIFT:   load_ready = wrap && sck && (bit_cnt_q == LAST_BIT);
            ROTATE:  load_ready = 1'b0;
            default: load_ready = 1'b0;
        endcase

        accept    = bus.load_valid && load_ready;
        frame_end = fall && (bit_cnt_q == LAST_BIT);
        // A stop arriving on the very edge that ends the frame still counts.
        stop_now  = (state_q == ROTATE) && (stop_q || bus.stop);

        if (accept) begin
            state_d = (bus.mode == MODE_ONESHOT) ? SHIFT : ROTATE;
        end else if (frame_end && ((state_q == SHIFT) || stop_now)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            sdo_q     <= 1'b0;
            done_q    <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            done_q <= frame_end;

            if (accept) begin
                shreg_q   <= bus.load_data;
                div_q     <= bus.div;
                bit_cnt_q <= '0;
                sdo_q     <= first_bit(bus.load_data);
            end else if (fall) begin
                if (state_d == IDLE) begin
                    bit_cnt_q <= '0;
                    sdo_q     <= 1'b0;
                end else begin
                    shreg_q   <= shreg_next;
                    sdo_q     <= first_bit(shreg_next);
                    bit_cnt_q <= frame_end ? '0 : bit_cnt_q + 1'b1;
                end
            end

            if (state_d == IDLE) begin
                stop_q <= 1'b0;
            end else if ((state_q == ROTATE) && bus.stop) begin
                stop_q <= 1'b1;
            end
        end
    end

    assign sdo            = sdo_q;
    assign bus.load_ready = load_ready;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: one MSB-first and one LSB-first
// instance share clock and reset. Expected bits and done times are queued
// when a frame is loaded and consumed as sck rises / done pulses appear.
// Time labels: the acceptance edge is T; the sample taken at the negedge
// that follows edge T+k-1 is labelled T+k.
module tb_serial_pattern_tx;

    typedef struct {
        int   t;
        logic busy;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;

    logic       tb_valid = 1'b0;
    logic [7:0] tb_data  = 8'h00;
    logic [7:0] tb_div   = 8'h00;
    logic       tb_mode  = 1'b0;
    logic       tb_stop  = 1'b0;

    logic m_sck, m_sdo, l_sck, l_sdo;
    logic o_sck, o_sdo, o_ready, o_busy, o_done;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rises, first_rise, last_rise, extra, ready_hi, period;
    int t;

    logic      exp_bits[$];
    done_exp_t exp_done[$];

    serial_pattern_tx_if #(.DATA_W(8), .DIV_W(8)) m_bus ();
    serial_pattern_tx_if #(.DATA_W(8), .DIV_W(8)) l_bus ();

    assign m_bus.load_valid = tb_valid & ~sel;
    assign m_bus.load_data  = tb_data;
    assign m_bus.div        = tb_div;
    assign m_bus.mode       = tb_mode;
    assign m_bus.stop       = tb_stop & ~sel;
    assign l_bus.load_valid = tb_valid & sel;
    assign l_bus.load_data  = tb_data;
    assign l_bus.div        = tb_div;
    assign l_bus.mode       = tb_mode;
    assign l_bus.stop       = tb_stop & sel;

    serial_pattern_tx #(.DATA_W(8), .DIV_W(8), .LSB_FIRST(1'b0)) u_msb (
        .clk (clk),
        .rst (rst),
        .bus (m_bus),
        .sck (m_sck),
        .sdo (m_sdo)
    );

    serial_pattern_tx #(.DATA_W(8), .DIV_W(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk (clk),
        .rst (rst),
        .bus (l_bus),
        .sck (l_sck),
        .sdo (l_sdo)
    );

    assign o_sck   = sel ? l_sck : m_sck;
    assign o_sdo   = sel ? l_sdo : m_sdo;
    assign o_ready = sel ? l_bus.load_ready : m_bus.load_ready;
    assign o_busy  = sel ? l_bus.busy : m_bus.busy;
    assign o_done  = sel ? l_bus.done : m_bus.done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sck"},   32'(o_sck),   0);
        check({tag, "_sdo"},   32'(o_sdo),   0);
        check({tag, "_ready"}, 32'(o_ready), 1);
        check({tag, "_busy"},  32'(o_busy),  0);
        check({tag, "_done"},  32'(o_done),  0);
    endtask

    task automatic clear_stats(input int p);
        rises      = 0;
        first_rise = -1;
        last_rise  = -1;
        extra      = 0;
        ready_hi   = 0;
        period     = p;
    endtask

    // Expected model: bit k of the frame is on sdo at the k-th sck rise;
    // done arrives 1 + 2*8*(d+1) cycles after the acceptance edge.
    task automatic push_frame(input logic [7:0] data, input bit lsb, input int ta,
                              input int d, input logic busy_after);
        done_exp_t e;
        for (int k = 0; k < 8; k++) exp_bits.push_back(lsb ? data[k] : data[7-k]);
        e.t    = ta + 1 + 16 * (d + 1);
        e.busy = busy_after;
        exp_done.push_back(e);
    endtask

    task automatic watch(input int n);
        logic      prev;
        int        label;
        done_exp_t e;
        prev = o_sck;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            label = cyc + 1;
            if (o_ready === 1'b1) ready_hi++;
            if (o_sck === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rises == 1) first_rise = label;
                if (last_rise >= 0) check("rise_gap", label - last_rise, period);
                last_rise = label;
                if (exp_bits.size() == 0) extra++;
                else check($sformatf("bit%0d", rises), 32'(o_sdo), 32'(exp_bits.pop_front()));
            end
            if (o_done === 1'b1) begin
                if (exp_done.size() == 0) extra++;
                else begin
                    e = exp_done.pop_front();
                    check("done_at", label, e.t);
                    check("done_busy", 32'(o_busy), 32'(e.busy));
                end
            end
            prev = o_sck;
        end
    endtask

    task automatic check_end(input string tag, input int n_rises);
        check({tag, "_rises"},     rises, n_rises);
        check({tag, "_extra"},     extra, 0);
        check({tag, "_bits_left"}, exp_bits.size(), 0);
        check({tag, "_done_left"}, exp_done.size(), 0);
    endtask

    initial begin
        // Reset and release.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst_msb");
        sel = 1'b1;
        check_idle("rst_lsb");
        sel = 1'b0;

        // One-shot, div=0, 0xA5, MSB first.
        clear_stats(2);
        tb_data = 8'hA5; tb_div = 8'd0; tb_mode = 1'b0; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_valid = 1'b0;
        push_frame(8'hA5, 1'b0, t, 0, 1'b0);
        check("A_first_bit", 32'(o_sdo),   1);
        check("A_busy",      32'(o_busy),  1);
        check("A_ready",     32'(o_ready), 0);
        watch(19);
        check_end("A", 8);
        check_idle("A_idle");

        // One-shot, div=3, 0x81, LSB first.
        sel = 1'b1;
        clear_stats(8);
        tb_data = 8'h81; tb_div = 8'd3; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_valid = 1'b0;
        push_frame(8'h81, 1'b1, t, 3, 1'b0);
        watch(66);
        check("B_first_rise", first_rise, t + 5);
        check_end("B", 8);
        check_idle("B_idle");
        sel = 1'b0;

        // Back-to-back one-shot frames, div=0, valid held high.
        clear_stats(2);
        tb_data = 8'hF0; tb_div = 8'd0; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_data = 8'h0F;
        push_frame(8'hF0, 1'b0, t, 0, 1'b1);
        push_frame(8'h0F, 1'b0, t + 16, 0, 1'b0);
        watch(15);
        check("C_ready_last", 32'(o_ready), 1);
        check("C_ready_cnt",  ready_hi, 1);
        watch(1);
        tb_valid = 1'b0;
        check("C_new_first", 32'(o_sdo), 0);
        watch(19);
        check_end("C", 16);
        check_idle("C_idle");

        // Rotate, div=1, 0xC3; stop pulsed in frame 2.
        clear_stats(4);
        tb_data = 8'hC3; tb_div = 8'd1; tb_mode = 1'b1; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_valid = 1'b0;
        push_frame(8'hC3, 1'b0, t, 1, 1'b1);
        push_frame(8'hC3, 1'b0, t + 32, 1, 1'b0);
        check("D_ready0", 32'(o_ready), 0);
        watch(44);
        tb_stop = 1'b1;
        watch(1);
        tb_stop = 1'b0;
        watch(18);
        check("D_ready_rot", ready_hi, 0);
        check("D_busy_rot", 32'(o_busy), 1);
        watch(12);
        check_end("D", 16);
        check_idle("D_idle");
        tb_mode = 1'b0;

        // div/mode changed mid-frame: no effect until the next acceptance.
        clear_stats(2);
        tb_data = 8'h3C; tb_div = 8'd0; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_valid = 1'b0;
        push_frame(8'h3C, 1'b0, t, 0, 1'b0);
        watch(6);
        tb_div = 8'd5; tb_mode = 1'b1;
        watch(13);
        check_end("E1", 8);
        clear_stats(12);
        tb_mode = 1'b0; tb_data = 8'h5A; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_valid = 1'b0;
        push_frame(8'h5A, 1'b0, t, 5, 1'b0);
        watch(100);
        check("E2_first_rise", first_rise, t + 7);
        check_end("E2", 8);
        check_idle("E2_idle");

        // Reset mid-frame: immediate abort, no done pulse afterwards.
        clear_stats(6);
        tb_data = 8'hFF; tb_div = 8'd2; tb_valid = 1'b1;
        @(negedge clk);
        t = cyc; tb_valid = 1'b0;
        push_frame(8'hFF, 1'b0, t, 2, 1'b0);
        watch(10);
        #2 rst = 1'b1;
        @(negedge clk);
        check_idle("F_rst");
        exp_bits.delete();
        exp_done.delete();
        clear_stats(6);
        watch(2);
        rst = 1'b0;
        watch(60);
        check("F_no_events", extra, 0);
        check_idle("F_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
